hazard_scoreboard: RTL

//  Parametrised hazard/forwarding unit for the 5-stage MIPS core (F/D/E/M/W). Holds a registered

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_fwd_src_match.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared hazard-unit types: forward-select codes, matcher hit stages, stage record
// and the MIPS Tnew/Tuse classes used by the decoder.
package hazard_pkg;

   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_M  = 2'd1;
   localparam logic [1:0] FWD_W  = 2'd2;

   typedef enum logic [1:0] {
      HIT_NONE = 2'd0,
      HIT_E    = 2'd1,
      HIT_M    = 2'd2,
      HIT_W    = 2'd3
   } hit_stage_t;

   localparam int REC_AW = 5;
   localparam int REC_TW = 2;

   typedef struct packed {
      logic              valid;
      logic [REC_AW-1:0] wa;
      logic [REC_TW-1:0] tnew;
   } stage_rec_t;

   localparam logic [REC_TW-1:0] TNEW_ALU    = 2'd1;
   localparam logic [REC_TW-1:0] TNEW_LOAD   = 2'd2;
   localparam logic [REC_TW-1:0] TUSE_BRANCH = 2'd0;
   localparam logic [REC_TW-1:0] TUSE_ALU    = 2'd1;
   localparam logic [REC_TW-1:0] TUSE_STORE  = 2'd2;

endpackage

// File: rtl/hazard_scoreboard_fwd_src_match.sv
// Combinational priority matcher of one source address against the E/M/W writer
// records (index 0 = E, 1 = M, 2 = W); the youngest matching stage wins.
module fwd_src_match
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int TNEW_W = 2
) (
   input  logic [REG_AW-1:0]   addr,
   input  logic [2:0]          rec_valid,
   input  logic [3*REG_AW-1:0] rec_wa,
   input  logic [3*TNEW_W-1:0] rec_tnew,
   output hit_stage_t          hit_stage,
   output logic [TNEW_W-1:0]   hit_tnew
);

   logic [2:0] match;

   for (genvar k = 0; k < 3; k++) begin : g_cmp
      assign match[k] = rec_valid[k] && (rec_wa[k*REG_AW +: REG_AW] == addr) &&
                        (addr != {REG_AW{1'b0}});
   end

   always_comb begin
      hit_stage = HIT_NONE;
      hit_tnew  = {TNEW_W{1'b0}};
      if (match[0]) begin
         hit_stage = HIT_E;
         hit_tnew  = rec_tnew[0 +: TNEW_W];
      end else if (match[1]) begin
         hit_stage = HIT_M;
         hit_tnew  = rec_tnew[TNEW_W +: TNEW_W];
      end else if (match[2]) begin
         hit_stage = HIT_W;
         hit_tnew  = rec_tnew[2*TNEW_W +: TNEW_W];
      end else begin
         hit_stage = HIT_NONE;
         hit_tnew  = {TNEW_W{1'b0}};
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding scoreboard for the 5-stage MIPS core: E/M/W writer records,
// D/E forward selects, D stall and mult/div busy. Optional HAZARD_PERF_CNT_EN stall counter.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_SRC     = 2,
   parameter int REG_AW      = 5,
   parameter int TNEW_W      = 2,
   parameter int MD_MULT_CYC = 5,
   parameter int MD_DIV_CYC  = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dec_valid,
   input  logic [REG_AW-1:0]           dec_wa,
   input  logic [TNEW_W-1:0]           dec_tnew,
   input  logic [NUM_SRC*REG_AW-1:0]   dec_src_addr,
   input  logic [NUM_SRC*TNEW_W-1:0]   dec_src_tuse,
   input  logic                        dec_md_use,
   input  logic                        e_md_start,
   input  logic                        e_md_div,
   output logic                        stall_d,
   output logic [NUM_SRC*2-1:0]        fwd_sel_d,
   output logic [NUM_SRC*2-1:0]        fwd_sel_e,
   output logic                        md_busy,
   output logic [31:0]                 perf_stall_cnt
);

   localparam int MD_MAX = (MD_DIV_CYC > MD_MULT_CYC) ? MD_DIV_CYC : MD_MULT_CYC;
   localparam int MD_W   = $clog2(MD_MAX + 1);

   function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] t);
      return (t != {TNEW_W{1'b0}}) ? t - {{(TNEW_W-1){1'b0}}, 1'b1} : {TNEW_W{1'b0}};
   endfunction

   // Records packed per stage: slot 0 = E, 1 = M, 2 = W
   logic [2:0]                rec_valid;
   logic [3*REG_AW-1:0]       rec_wa;
   logic [3*TNEW_W-1:0]       rec_tnew;
   logic [NUM_SRC*REG_AW-1:0] src_e;
   logic [MD_W-1:0]           md_cnt;

   logic                      e_load;
   logic [REG_AW-1:0]         e_wa;
   logic [TNEW_W-1:0]         e_tnew;
   logic [NUM_SRC-1:0]        data_hz;

   assign e_load = dec_valid && !stall_d;
   assign e_wa   = e_load ? dec_wa : {REG_AW{1'b0}};
   assign e_tnew = !e_load ? {TNEW_W{1'b0}} :
                   (dec_tnew == {TNEW_W{1'b0}}) ? {{(TNEW_W-1){1'b0}}, 1'b1} : dec_tnew;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      hit_stage_t        hit_d, hit_e;
      logic [TNEW_W-1:0] tnew_d, tnew_e;

      fwd_src_match #(.REG_AW(REG_AW), .TNEW_W(TNEW_W)) u_match_d (
         .addr      (dec_src_addr[i*REG_AW +: REG_AW]),
         .rec_valid (rec_valid),
         .rec_wa    (rec_wa),
         .rec_tnew  (rec_tnew),
         .hit_stage (hit_d),
         .hit_tnew  (tnew_d)
      );

      // E-stage operands are already past E, so only M and W can supply them
      fwd_src_match #(.REG_AW(REG_AW), .TNEW_W(TNEW_W)) u_match_e (
         .addr      (src_e[i*REG_AW +: REG_AW]),
         .rec_valid ({rec_valid[2:1], 1'b0}),
         .rec_wa    (rec_wa),
         .rec_tnew  (rec_tnew),
         .hit_stage (hit_e),
         .hit_tnew  (tnew_e)
      );

      assign data_hz[i] = (hit_d != HIT_NONE) && (tnew_d > dec_src_tuse[i*TNEW_W +: TNEW_W]);
      assign fwd_sel_d[2*i +: 2] = ((hit_d == HIT_M) && (tnew_d == {TNEW_W{1'b0}})) ? FWD_M :
                                   (hit_d == HIT_W) ? FWD_W : FWD_RF;
      assign fwd_sel_e[2*i +: 2] = ((hit_e == HIT_M) && (tnew_e == {TNEW_W{1'b0}})) ? FWD_M :
                                   (hit_e == HIT_W) ? FWD_W : FWD_RF;
   end

   assign md_busy = (md_cnt != {MD_W{1'b0}});
   assign stall_d = (|data_hz) || (dec_md_use && (md_busy || e_md_start));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rec_valid <= 3'b000;
         rec_wa    <= {(3*REG_AW){1'b0}};
         rec_tnew  <= {(3*TNEW_W){1'b0}};
         src_e     <= {(NUM_SRC*REG_AW){1'b0}};
      end else begin
         rec_valid <= {rec_valid[1], rec_valid[0], e_load};
         rec_wa    <= {rec_wa[REG_AW +: REG_AW], rec_wa[0 +: REG_AW], e_wa};
         rec_tnew  <= {tnew_age(rec_tnew[TNEW_W +: TNEW_W]), tnew_age(rec_tnew[0 +: TNEW_W]), e_tnew};
         src_e     <= e_load ? dec_src_addr : {(NUM_SRC*REG_AW){1'b0}};
      end
   end

   // A new start always reloads, even over a running operation
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         md_cnt <= {MD_W{1'b0}};
      end else if (e_md_start) begin
         md_cnt <= e_md_div ? MD_W'(MD_DIV_CYC) : MD_W'(MD_MULT_CYC);
      end else if (md_busy) begin
         md_cnt <= md_cnt - {{(MD_W-1){1'b0}}, 1'b1};
      end else begin
         md_cnt <= md_cnt;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_stall_cnt <= 32'd0;
      end else if (stall_d && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
         perf_stall_cnt <= perf_stall_cnt;
      end
   end
`else
   assign perf_stall_cnt = 32'd0;
`endif

endmodule
